// File: rtl/golomb_job_loader.sv
// Host byte-stream front end for the ruler assembly stage: loads preset marks, validates,
// pulses the assembly reset, waits for done and streams a report. Optional: JOB_WATCHDOG_EN.
module golomb_job_loader #(
  parameter int unsigned NUMPOSITIONS    = 5,
  parameter int unsigned VALUEBITS       = 9,
  parameter int unsigned RESET_CYCLES    = 4,
  parameter int unsigned WATCHDOG_CYCLES = 1048576
) (
  input  logic                                  FXCLK,
  input  logic                                  RESET_IN,
  input  logic [7:0]                            rx_data,
  input  logic                                  rx_valid,
  output logic                                  rx_ready,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic [(NUMPOSITIONS+1)*VALUEBITS-1:0] firstvalues,
  output logic                                  asm_reset,
  input  logic                                  asm_done,
  input  logic [(NUMPOSITIONS+1)*VALUEBITS-1:0] asm_marks,
  input  logic [5:0]                            asm_nresults,
  output logic                                  busy,
  output logic                                  error
);

  localparam int unsigned NV         = NUMPOSITIONS + 1;
  localparam int unsigned FVW        = NV * VALUEBITS;
  localparam int unsigned LOAD_BYTES = 2 * NV;
  localparam int unsigned RPT_BYTES  = 2 * NV + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [7:0] CMD_LOAD   = 8'h4C;
  localparam logic [7:0] HDR_DONE   = 8'hA5;
  localparam logic [7:0] HDR_REJECT = 8'hEE;
`ifdef JOB_WATCHDOG_EN
  localparam logic [7:0] HDR_WDOG   = 8'h5A;
`endif

  logic [2:0]     state;
  logic [7:0]     byte_cnt;
  logic [7:0]     lo_byte;
  logic           bad;
  logic [15:0]    pulse_cnt;
  logic           run_first;
  logic [FVW-1:0] marks_buf;
  logic [5:0]     nres_buf;
  logic [7:0]     rpt_idx;

  logic           rx_fire;
  logic           tx_fire;
  logic [15:0]    ld_word;
  logic           ld_bad;
  logic           reject;
  logic [VALUEBITS-1:0] chk_last;
  logic [VALUEBITS-1:0] chk_v;
  logic [7:0]     nxt_idx;
  logic [7:0]     nxt_byte;
  logic [15:0]    mark16;

`ifdef JOB_WATCHDOG_EN
  logic [31:0]    wd_cnt;
  logic           wd_expire;
  assign wd_expire = (wd_cnt == 32'(WATCHDOG_CYCLES - 1));
`endif

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign busy    = (state != S_IDLE);
  assign ld_word = {rx_data, lo_byte};
  assign ld_bad  = ((ld_word >> VALUEBITS) != 16'd0);

  // Zero slots are "not preset"; each nonzero slot must exceed the nearest nonzero before it.
  always_comb begin
    chk_last = firstvalues[NUMPOSITIONS*VALUEBITS +: VALUEBITS];
    chk_v    = '0;
    reject   = bad | (chk_last != '0);
    for (int unsigned i = 1; i < NV; i++) begin
      chk_v = firstvalues[(NUMPOSITIONS-i)*VALUEBITS +: VALUEBITS];
      if (chk_v != '0) begin
        if (chk_v <= chk_last) reject = 1'b1;
        chk_last = chk_v;
      end
    end
  end

  // Report byte following the one currently on tx_data: marks low/high, then nresults.
  always_comb begin
    nxt_idx  = rpt_idx + 8'd1;
    nxt_byte = '0;
    mark16   = '0;
    if (nxt_idx == 8'(RPT_BYTES - 1)) begin
      nxt_byte = {2'b00, nres_buf};
    end else begin
      for (int unsigned j = 0; j < NV; j++) begin
        mark16 = 16'(marks_buf[(NUMPOSITIONS-j)*VALUEBITS +: VALUEBITS]);
        if (nxt_idx == 8'(2*j + 1)) nxt_byte = mark16[7:0];
        if (nxt_idx == 8'(2*j + 2)) nxt_byte = mark16[15:8];
      end
    end
  end

  always_ff @(posedge FXCLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      lo_byte     <= '0;
      bad         <= 1'b0;
      pulse_cnt   <= '0;
      run_first   <= 1'b0;
      marks_buf   <= '0;
      nres_buf    <= '0;
      rpt_idx     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rx_ready    <= 1'b0;
      asm_reset   <= 1'b1;
      firstvalues <= '0;
      error       <= 1'b0;
`ifdef JOB_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire && rx_data == CMD_LOAD) begin
            state    <= S_LOAD;
            error    <= 1'b0;
            byte_cnt <= '0;
            bad      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (rx_fire) begin
            if (!byte_cnt[0]) begin
              lo_byte <= rx_data;
            end else begin
              if (ld_bad) bad <= 1'b1;
              for (int unsigned i = 0; i < NV; i++) begin
                if (byte_cnt[7:1] == 7'(i))
                  firstvalues[(NUMPOSITIONS-i)*VALUEBITS +: VALUEBITS] <= ld_word[VALUEBITS-1:0];
              end
            end
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(LOAD_BYTES - 1)) begin
              state    <= S_CHECK;
              rx_ready <= 1'b0;
            end
          end
        end

        S_CHECK: begin
          if (reject) begin
            error       <= 1'b1;
            firstvalues <= '0;
            marks_buf   <= '0;
            nres_buf    <= '0;
            rpt_idx     <= '0;
            tx_data     <= HDR_REJECT;
            tx_valid    <= 1'b1;
            state       <= S_REPORT;
          end else begin
            pulse_cnt <= '0;
            state     <= S_PULSE;
          end
        end

        S_PULSE: begin
          if (pulse_cnt == 16'(RESET_CYCLES - 1)) begin
            asm_reset <= 1'b0;
            run_first <= 1'b1;
            state     <= S_RUN;
`ifdef JOB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end else begin
            pulse_cnt <= pulse_cnt + 16'd1;
          end
        end

        S_RUN: begin
          run_first <= 1'b0;
          if (!run_first && asm_done) begin
            marks_buf <= asm_marks;
            nres_buf  <= asm_nresults;
            rpt_idx   <= '0;
            tx_data   <= HDR_DONE;
            tx_valid  <= 1'b1;
            state     <= S_REPORT;
          end
`ifdef JOB_WATCHDOG_EN
          else if (wd_expire) begin
            marks_buf <= asm_marks;
            nres_buf  <= asm_nresults;
            rpt_idx   <= '0;
            tx_data   <= HDR_WDOG;
            tx_valid  <= 1'b1;
            asm_reset <= 1'b1;
            state     <= S_REPORT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end

        S_REPORT: begin
          if (tx_fire) begin
            if (rpt_idx == 8'(RPT_BYTES - 1)) begin
              tx_valid  <= 1'b0;
              tx_data   <= '0;
              asm_reset <= 1'b1;
              rx_ready  <= 1'b1;
              state     <= S_IDLE;
            end else begin
              rpt_idx <= nxt_idx;
              tx_data <= nxt_byte;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golomb_job_loader.sv
// Self-checking bench for golomb_job_loader: directed and randomized jobs against a
// behavioural model of validation and report contents.
module tb_golomb_job_loader;

  localparam int unsigned NP  = 5;
  localparam int unsigned VB  = 9;
  localparam int unsigned RC  = 4;
  localparam int unsigned WD  = 100;
  localparam int unsigned FVW = (NP + 1) * VB;

  typedef logic [15:0] words_t [NP+1];
  typedef logic [VB-1:0] marks_t [NP+1];
  typedef logic [7:0] bytes_t [2*NP+4];

  logic           FXCLK = 1'b0;
  logic           RESET_IN = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [FVW-1:0] firstvalues;
  logic           asm_reset;
  logic           asm_done = 1'b0;
  logic [FVW-1:0] asm_marks = '0;
  logic [5:0]     asm_nresults = '0;
  logic           busy;
  logic           error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned arst_low = 0;

  golomb_job_loader #(
    .NUMPOSITIONS(NP), .VALUEBITS(VB), .RESET_CYCLES(RC), .WATCHDOG_CYCLES(WD)
  ) dut (
    .FXCLK(FXCLK), .RESET_IN(RESET_IN),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .firstvalues(firstvalues), .asm_reset(asm_reset),
    .asm_done(asm_done), .asm_marks(asm_marks), .asm_nresults(asm_nresults),
    .busy(busy), .error(error)
  );

  always #5 FXCLK = ~FXCLK;

  always @(negedge FXCLK) if (RESET_IN && !asm_reset) arst_low++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic bit model_accept(input words_t w);
    int unsigned last = 0;
    for (int i = 0; i <= NP; i++) if (w[i] >= (16'd1 << VB)) return 1'b0;
    if (w[0] != 0) return 1'b0;
    for (int i = 1; i <= NP; i++) begin
      if (w[i] != 0) begin
        if (w[i] <= last) return 1'b0;
        last = w[i];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [FVW-1:0] pack(input marks_t m);
    logic [FVW-1:0] r = '0;
    for (int i = 0; i <= NP; i++) r = (r << VB) | FVW'(m[i]);
    return r;
  endfunction

  function automatic bytes_t build_report(input logic [7:0] hdr, input marks_t m, input logic [5:0] nr);
    bytes_t b;
    b[0] = hdr;
    for (int i = 0; i <= NP; i++) begin
      b[1+2*i] = 8'(m[i] % 256);
      b[2+2*i] = 8'(m[i] / 256);
    end
    b[2*NP+3] = {2'b00, nr};
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned k = 0;
    @(negedge FXCLK);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 100) begin @(negedge FXCLK); k++; end
    if (!rx_ready) timeout("rx_ready_wait");
    else begin @(posedge FXCLK); #1; end
    rx_valid = 1'b0;
  endtask

  task automatic send_job(input words_t w);
    send_byte(8'h4C);
    check("error_clear", error, 0);
    for (int i = 0; i <= NP; i++) begin
      send_byte(w[i][7:0]);
      send_byte(w[i][15:8]);
    end
  endtask

  // Counts cycles with asm_reset high until it drops; ends on the first cycle with it low.
  task automatic wait_run(output int unsigned cnt);
    cnt = 0;
    forever begin
      @(negedge FXCLK);
      if (!asm_reset || cnt >= 200) break;
      cnt++;
    end
    if (asm_reset) timeout("asm_reset_drop");
  endtask

  task automatic collect(input bytes_t exp, input int mode);
    int unsigned idx = 0, cyc = 0;
    bit stalled = 0, tr;
    logic [7:0] held = '0;
    while (idx < 2*NP+4 && cyc < 400) begin
      @(negedge FXCLK);
      cyc++;
      if (stalled) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, held);
      end
      tr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      tx_ready = tr;
      if (tx_valid && tr) begin
        check($sformatf("tx_byte%0d", idx), tx_data, exp[idx]);
        idx++;
        stalled = 0;
      end else begin
        stalled = tx_valid;
        held    = tx_data;
      end
    end
    if (idx < 2*NP+4) timeout("report_bytes");
    if (mode == 0) check("tx_gapless", cyc, 2*NP+4);
    @(negedge FXCLK);
    tx_ready = 1'b0;
    check("end_tx_valid", tx_valid, 0);
    check("end_busy", busy, 0);
    check("end_asm_reset", asm_reset, 1);
  endtask

  task automatic do_job(input words_t w, input marks_t m, input logic [5:0] nr,
                        input int mode, input int unsigned dly);
    bit acc = model_accept(w);
    int unsigned cnt, low0;
    marks_t wm;
    for (int i = 0; i <= NP; i++) wm[i] = w[i][VB-1:0];
    low0 = arst_low;
    send_job(w);
    if (acc) begin
      wait_run(cnt);
      check("pulse_len", cnt, 1 + RC);
      check("fv_loaded", firstvalues, pack(wm));
      check("run_busy", busy, 1);
      rx_data  = 8'h4C;
      rx_valid = 1'b1;
      for (int unsigned k = 0; k < dly; k++) @(negedge FXCLK);
      check("run_rx_ready", rx_ready, 0);
      rx_valid = 1'b0;
      asm_marks    = pack(m);
      asm_nresults = nr;
      asm_done     = 1'b1;
      collect(build_report(8'hA5, m, nr), mode);
      asm_done = 1'b0;
      check("acc_error", error, 0);
    end else begin
      @(negedge FXCLK);
      collect(build_report(8'hEE, '{default: '0}, 6'd0), mode);
      check("rej_error", error, 1);
      check("rej_fv", firstvalues, 0);
      check("rej_asm_reset_held", arst_low - low0, 0);
    end
  endtask

  initial begin
    words_t w;
    marks_t m;
    int unsigned cnt;

    #12;
    check("rst_asm_reset", asm_reset, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_fv", firstvalues, 0);
    @(negedge FXCLK);
    RESET_IN = 1'b1;
    #1 check("rel_rx_ready_low", rx_ready, 0);
    @(negedge FXCLK);
    check("rel_rx_ready_high", rx_ready, 1);

    send_byte(8'h12);
    check("idle_drop_busy", busy, 0);

    w = '{16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0};
    do_job(w, '{9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17}, 6'd2, 0, 3);

    w = '{16'h0, 16'h5, 16'h3, 16'h0, 16'h0, 16'h0};
    do_job(w, '{default: '0}, 6'd0, 0, 1);

    w = '{16'h0, 16'h0203, 16'h0, 16'h0, 16'h0, 16'h0};
    do_job(w, '{default: '0}, 6'd0, 2, 1);

    w = '{16'h0, 16'h0105, 16'h0, 16'h0, 16'h0, 16'h01FF};
    do_job(w, '{9'd0, 9'd261, 9'd300, 9'd400, 9'd450, 9'd511}, 6'd63, 1, 2);

    for (int i = 0; i <= NP; i++) m[i] = VB'($urandom_range(0, 511));
    do_job('{16'h0, 16'h2, 16'h7, 16'h0, 16'h20, 16'h40}, m, 6'($urandom_range(0, 63)), 1, 5);

    send_byte(8'h4C);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
    @(negedge FXCLK);
    RESET_IN = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_asm_reset", asm_reset, 1);
    check("midrst_fv", firstvalues, 0);
    @(negedge FXCLK);
    RESET_IN = 1'b1;
    @(negedge FXCLK);
    check("midrst_rx_ready_back", rx_ready, 1);
    do_job('{16'h0, 16'h3, 16'h0, 16'h9, 16'h0, 16'h0}, '{9'd0, 9'd3, 9'd5, 9'd9, 9'd14, 9'd30}, 6'd7, 0, 1);

    for (int t = 0; t < 12; t++) begin
      int unsigned last = 0;
      w[0] = 16'h0;
      for (int i = 1; i <= NP; i++) begin
        if ($urandom_range(0, 2) == 0) w[i] = 16'h0;
        else begin last = last + $urandom_range(1, 60); w[i] = 16'(last); end
      end
      case ($urandom_range(0, 3))
        1: w[0] = 16'($urandom_range(1, 100));
        2: w[$urandom_range(2, NP)] = 16'($urandom_range(1, 40));
        3: w[$urandom_range(1, NP)][$urandom_range(VB, 15)] = 1'b1;
        default: ;
      endcase
      for (int i = 0; i <= NP; i++) m[i] = VB'($urandom_range(0, 511));
      do_job(w, m, 6'($urandom_range(0, 63)), $urandom_range(0, 2), $urandom_range(1, 8));
    end

`ifdef JOB_WATCHDOG_EN
    for (int i = 0; i <= NP; i++) m[i] = VB'($urandom_range(0, 511));
    send_job('{16'h0, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0});
    wait_run(cnt);
    asm_marks    = pack(m);
    asm_nresults = 6'd33;
    cnt = 1;
    forever begin
      @(negedge FXCLK);
      if (tx_valid || cnt > 3 * WD) break;
      cnt++;
    end
    check("wd_cycles", cnt, WD);
    check("wd_asm_reset", asm_reset, 1);
    collect(build_report(8'h5A, m, 6'd33), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
